imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Reverse of the datapath immediate extender.
- Accepts a 32-bit constant or a byte branch offset and emits the minimal stream of {imm16, EOp} tokens; extending those tokens and OR-combining them rebuilds the original value.
- Sits between the test-program/assembler front end and the instruction packer, which turns tokens into addiu/ori/lui/branch fields.
- EOp codes: 00 sign-ext, 01 zero-ext, 10 upper (imm<<16), 11 sign-ext<<2.

Parameters:
- CNT_W, 16, width of the statistics counters (used only with IMM_ENC_STATS_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- in_value  input  32  constant or byte offset.
- in_branch  input  1  1 = branch offset (EOp 11 only); 0 = general constant.
- out_valid  output  1  token valid.
- out_ready  input  1  consumer accepts token.
- out_imm  output  16  token immediate.
- out_eop  output  2  token EOp.
- out_last  output  1  final token of the current request.
- out_err  output  1  branch offset not encodable; the token is a dummy (imm 0, EOp 11, last 1).

Behaviour:
- Reset (async): state IDLE, in_ready 1, out_valid 0, out_imm 0, out_eop 00, out_last 0, out_err 0, internal value register 0.
- A request is accepted when in_valid && in_ready. On acceptance the block registers in_value and the classification, and moves to EMIT1.
- Token outputs are registered. The first token is valid the cycle after acceptance, so latency is 1.
- Classification, constant mode (first match wins):
  - v[31:16] == {16{v[15]}}: one token, imm v[15:0], EOp 00.
  - v[31:16] == 0: one token, imm v[15:0], EOp 01.
  - v[15:0] == 0: one token, imm v[31:16], EOp 10.
  - otherwise: two tokens. First: imm v[31:16], EOp 10, last 0. Second: imm v[15:0], EOp 01, last 1.
- Classification, branch mode:
  - Encodable iff v[1:0] == 0 and v[31:17] == {15{v[17]}}. Then one token: imm v[17:2], EOp 11, last 1.
  - Otherwise one error token (err 1).
- States:
  - IDLE: wait for acceptance, then go to EMIT1.
  - EMIT1: hold the token while out_valid && !out_ready. On handshake, go to EMIT2 if two tokens are needed, else IDLE.
  - EMIT2: hold the token until handshake, then go to IDLE.
- Output stability: out_imm, out_eop, out_last and out_err must not change while out_valid && !out_ready.
- in_ready is low outside IDLE. A new request is never accepted in the same cycle as a final handshake, so sustained throughput is at most one request per 2 cycles (3 cycles for two-token requests).
- out_valid is 0 in IDLE. out_err is 0 on every token except the branch error token.
- Reset asserted mid-stream drops the pending request immediately; no partial token survives.

Optional Feature:
- Macro IMM_ENC_STATS_EN. When defined, adds three outputs: cnt_single, cnt_double, cnt_err (each CNT_W bits).
  - Each counter increments on the final-token handshake of a request of that kind.
  - Counters saturate at all-ones and clear on reset.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - EOp constants: EOP_SEXT 2'b00, EOP_ZEXT 2'b01, EOP_LUI 2'b10, EOP_BR 2'b11.
  - State encoding: IDLE, EMIT1, EMIT2.
- One natural sub-module: imm_classify. It is purely combinational: value + branch flag → token count, token imm/EOp pairs, err.
- The FSM and the output registers stay in imm_encoder.

Test Plan:
- in_value 0xFFFF8000, branch 0, out_ready 1 → one token, imm 0x8000, EOp 00, last 1, one cycle after accept.
- in_value 0x0000ABCD → imm 0xABCD, EOp 01. in_value 0x12340000 → imm 0x1234, EOp 10.
- in_value 0x12345678 with out_ready held 0 for 3 cycles → first token (0x1234, 10, last 0) held stable, then (0x5678, 01, last 1); in_ready low throughout.
- branch 1, value 0xFFFFFFFC → imm 0xFFFF, EOp 11. Value 0x00000006 → err 1. Value 0x00020000 → err 1.
- Assert reset while in EMIT2 → out_valid 0, in_ready 1 immediately (asynchronous). Next request 0x00000001 → EOp 00, imm 0x0001.
- Random values: for every completed request, the OR of the ext(imm, EOp) of its tokens equals the input value whenever err is 0. With IMM_ENC_STATS_EN, counters match the bench's tallies.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder: EOp codes, FSM states, token type.
package imm_encoder_pkg;

  localparam logic [1:0] EOP_SEXT = 2'b00;
  localparam logic [1:0] EOP_ZEXT = 2'b01;
  localparam logic [1:0] EOP_LUI  = 2'b10;
  localparam logic [1:0] EOP_BR   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] imm;
    logic [1:0]  eop;
  } token_t;

endpackage

// File: rtl/imm_classify.sv
// Combinational classifier: picks the minimal {imm16, EOp} token sequence for a
// 32-bit constant or a byte branch offset.
module imm_classify
  import imm_encoder_pkg::*;
(
  input  logic [31:0] value,
  input  logic        branch,
  output logic        two,
  output token_t      tok0,
  output token_t      tok1,
  output logic        err
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can leave
    // one unassigned and infer a latch.
    two  = 1'b0;
    err  = 1'b0;
    tok0 = '{imm: value[15:0], eop: EOP_SEXT};
    tok1 = '{imm: value[15:0], eop: EOP_ZEXT};
    if (branch) begin
      tok0.eop = EOP_BR;
      if (value[1:0] == 2'b00 && value[31:17] == {15{value[17]}}) begin
        tok0.imm = value[17:2];
      end else begin
        tok0.imm = '0;
        err      = 1'b1;
      end
    end else if (value[31:16] == {16{value[15]}}) begin
      tok0.eop = EOP_SEXT;
    end else if (value[31:16] == 16'h0000) begin
      tok0.eop = EOP_ZEXT;
    end else if (value[15:0] == 16'h0000) begin
      tok0 = '{imm: value[31:16], eop: EOP_LUI};
    end else begin
      // Upper half via lui, lower half OR-ed in with a zero-extended ori.
      tok0 = '{imm: value[31:16], eop: EOP_LUI};
      two  = 1'b1;
    end
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: streams {imm16, EOp} tokens with valid/ready handshakes.
// Define IMM_ENC_STATS_EN to add saturating CNT_W-bit request counters.
module imm_encoder
  import imm_encoder_pkg::*;
`ifdef IMM_ENC_STATS_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_value,
  input  logic             in_branch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_imm,
  output logic [1:0]       out_eop,
  output logic             out_last,
  output logic             out_err
`ifdef IMM_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double,
  output logic [CNT_W-1:0] cnt_err
`endif
);

  state_t      state, state_d;
  logic [31:0] val_q, val_d;
  logic        br_q, br_d, two_q, two_d;
  logic        valid_d, last_d, err_d;
  token_t      tok_d;

  logic [31:0] cls_value;
  logic        cls_branch, cls_two, cls_err;
  token_t      cls_tok0, cls_tok1;

  logic accept, hs;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign hs       = out_valid && out_ready;

  // One classifier serves both the incoming request and the held one.
  assign cls_value  = (state == IDLE) ? in_value  : val_q;
  assign cls_branch = (state == IDLE) ? in_branch : br_q;

  imm_classify u_classify (
    .value  (cls_value),
    .branch (cls_branch),
    .two    (cls_two),
    .tok0   (cls_tok0),
    .tok1   (cls_tok1),
    .err    (cls_err)
  );

  always_comb begin
    state_d = state;
    valid_d = out_valid;
    tok_d   = '{imm: out_imm, eop: out_eop};
    last_d  = out_last;
    err_d   = out_err;
    val_d   = val_q;
    br_d    = br_q;
    two_d   = two_q;
    unique case (state)
      IDLE: if (accept) begin
        state_d = EMIT1;
        valid_d = 1'b1;
        tok_d   = cls_tok0;
        last_d  = !cls_two;
        err_d   = cls_err;
        val_d   = in_value;
        br_d    = in_branch;
        two_d   = cls_two;
      end
      EMIT1: if (hs) begin
        if (two_q) begin
          state_d = EMIT2;
          tok_d   = cls_tok1;
          last_d  = 1'b1;
          err_d   = 1'b0;
        end else begin
          state_d = IDLE;
          valid_d = 1'b0;
          tok_d   = '0;
          last_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      EMIT2: if (hs) begin
        state_d = IDLE;
        valid_d = 1'b0;
        tok_d   = '0;
        last_d  = 1'b0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_eop   <= EOP_SEXT;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      val_q     <= '0;
      br_q      <= 1'b0;
      two_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_d;
      out_valid <= valid_d;
      out_imm   <= tok_d.imm;
      out_eop   <= tok_d.eop;
      out_last  <= last_d;
      out_err   <= err_d;
      val_q     <= val_d;
      br_q      <= br_d;
      two_q     <= two_d;
    end
  end

`ifdef IMM_ENC_STATS_EN
  logic final_hs;
  assign final_hs = hs && out_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_single <= '0;
      cnt_double <= '0;
      cnt_err    <= '0;
    end else if (final_hs) begin
      if (out_err) begin
        if (cnt_err != '1) cnt_err <= cnt_err + 1'b1;
      end else if (state == EMIT2) begin
        if (cnt_double != '1) cnt_double <= cnt_double + 1'b1;
      end else begin
        if (cnt_single != '1) cnt_single <= cnt_single + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases plus random requests
// checked against a token model derived from the extension rules.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        in_branch;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic [1:0]  out_eop;
  logic        out_last;
  logic        out_err;
`ifdef IMM_ENC_STATS_EN
  logic [15:0] cnt_single, cnt_double, cnt_err;
  int          t_single, t_double, t_err;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .in_branch  (in_branch),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_eop    (out_eop),
    .out_last   (out_last),
    .out_err    (out_err)
`ifdef IMM_ENC_STATS_EN
    ,
    .cnt_single (cnt_single),
    .cnt_double (cnt_double),
    .cnt_err    (cnt_err)
`endif
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Value rebuilt by the datapath extender from one token.
  function automatic logic [31:0] ext(input logic [15:0] imm, input logic [1:0] eop);
    logic [31:0] s;
    s = {{16{imm[15]}}, imm};
    case (eop)
      2'b00:   return s;
      2'b01:   return {16'h0000, imm};
      2'b10:   return {imm, 16'h0000};
      default: return s << 2;
    endcase
  endfunction

  // Reference: cheapest single token whose extension reproduces v, else lui+ori.
  task automatic model(input logic [31:0] v, input logic br, output int n,
                       output logic [15:0] i0, output logic [1:0] e0,
                       output logic [15:0] i1, output logic [1:0] e1, output bit er);
    n = 1; er = 0; i1 = 16'h0; e1 = 2'b00;
    if (br) begin
      i0 = v[17:2]; e0 = 2'b11;
      if (ext(i0, 2'b11) != v) begin er = 1; i0 = 16'h0; end
    end else if (ext(v[15:0], 2'b00) == v) begin
      i0 = v[15:0]; e0 = 2'b00;
    end else if (ext(v[15:0], 2'b01) == v) begin
      i0 = v[15:0]; e0 = 2'b01;
    end else if (ext(v[31:16], 2'b10) == v) begin
      i0 = v[31:16]; e0 = 2'b10;
    end else begin
      n = 2; i0 = v[31:16]; e0 = 2'b10; i1 = v[15:0]; e1 = 2'b01;
    end
  endtask

  task automatic send(input logic [31:0] v, input logic br);
    int w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    check("in_ready_wait", in_ready, 1'b1);
    in_valid = 1'b1; in_value = v; in_branch = br;
    @(negedge clk);
    in_valid = 1'b0;
    check("latency1_valid", out_valid, 1'b1);
    check("busy_in_ready", in_ready, 1'b0);
  endtask

  task automatic expect_tok(input string tag, input logic [15:0] imm, input logic [1:0] eop,
                            input logic last, input logic er);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_imm"}, out_imm, imm);
    check({tag, "_eop"}, out_eop, eop);
    check({tag, "_last"}, out_last, last);
    check({tag, "_err"}, out_err, er);
  endtask

  task automatic run_req(input logic [31:0] v, input logic br, input int stall);
    int n; logic [15:0] i0, i1; logic [1:0] e0, e1; bit er;
    logic [15:0] imm; logic [1:0] eop;
    logic [31:0] acc = 32'h0;
    model(v, br, n, i0, e0, i1, e1, er);
    send(v, br);
    for (int t = 0; t < n; t++) begin
      imm = (t == 0) ? i0 : i1;
      eop = (t == 0) ? e0 : e1;
      for (int s = 0; s < stall; s++) begin
        out_ready = 1'b0;
        expect_tok("stall_tok", imm, eop, t == n - 1, er);
        check("stall_in_ready", in_ready, 1'b0);
        @(negedge clk);
      end
      out_ready = 1'b1;
      expect_tok("tok", imm, eop, t == n - 1, er);
      acc |= ext(out_imm, out_eop);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("done_valid", out_valid, 1'b0);
    check("done_in_ready", in_ready, 1'b1);
    if (!er) check("reconstruct", acc, v);
`ifdef IMM_ENC_STATS_EN
    if (er) t_err++; else if (n == 2) t_double++; else t_single++;
`endif
  endtask

  initial begin
    logic [31:0] r, v;
    logic        br;
    reset = 1'b1; in_valid = 1'b0; in_value = '0; in_branch = 1'b0; out_ready = 1'b0;
`ifdef IMM_ENC_STATS_EN
    t_single = 0; t_double = 0; t_err = 0;
`endif
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_imm", out_imm, 16'h0);
    check("rst_out_eop", out_eop, 2'b00);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_err", out_err, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    run_req(32'hFFFF8000, 1'b0, 0);
    run_req(32'h0000ABCD, 1'b0, 0);
    run_req(32'h12340000, 1'b0, 0);
    run_req(32'h12345678, 1'b0, 3);
    run_req(32'hFFFFFFFC, 1'b1, 0);
    run_req(32'h00000006, 1'b1, 0);
    run_req(32'h00020000, 1'b1, 1);
    run_req(32'h0001FFFC, 1'b1, 0);
    run_req(32'h00000000, 1'b0, 0);

    // Reset while the second token is pending must clear the stream at once.
    send(32'h12345678, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    expect_tok("emit2_tok", 16'h5678, 2'b01, 1'b1, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_in_ready", in_ready, 1'b1);
    check("async_rst_last", out_last, 1'b0);
    @(negedge clk);
    reset = 1'b0;
`ifdef IMM_ENC_STATS_EN
    check("rst_cnt_single", cnt_single, 16'h0);
    t_single = 0; t_double = 0; t_err = 0;
`endif
    run_req(32'h00000001, 1'b0, 0);

    for (int k = 0; k < 60; k++) begin
      r  = $urandom;
      br = 1'b0;
      case ($urandom_range(0, 4))
        0: v = {{16{r[15]}}, r[15:0]};
        1: v = {16'h0000, r[15:0]};
        2: v = {r[15:0], 16'h0000};
        3: v = r;
        default: begin
          br = 1'b1;
          v  = ($urandom_range(0, 1) == 0) ? {{14{r[17]}}, r[17:2], 2'b00} : r;
        end
      endcase
      run_req(v, br, $urandom_range(0, 2));
    end

`ifdef IMM_ENC_STATS_EN
    check("cnt_single", cnt_single, t_single);
    check("cnt_double", cnt_double, t_double);
    check("cnt_err", cnt_err, t_err);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
